serial_cmd_master: RTL and testbench

Initiator end of the board's UART command protocol. Takes one command request (opcode, up to 8 argument bytes, expected reply length) and serialises it to a byte-level UART transmitter. It then collects the responder's reply bytes into a 64-byte buffer and reports done or timeout. It sits between control/host logic on a master board and the UART tx/rx byte cores that link to a trigger board's command processor.

---
 rtl/serial_cmd_master.sv | 161 ++++++++++++++++
 tb/tb_serial_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_master.sv
// UART command initiator: serialises opcode + up to 8 arg bytes, then collects up to 64 reply bytes.
// Latency: one tx byte per 2 clocks when txBusy is low; sending stalls while txBusy is high; reply idle gaps bounded by TIMEOUT_CYCLES.
module serial_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [3:0]  cmd_nargs,
  input  logic [63:0] cmd_args,
  input  logic [6:0]  cmd_nresp,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [6:0]  resp_count,
  input  logic [5:0]  resp_rd_addr,
  output logic [7:0]  resp_rd_data
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_WAIT = 3'd1,
    SEND_GAP  = 3'd2,
    RECV      = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  nargs;
    logic [63:0] args;
    logic [6:0]  nresp;
  } cmd_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  cmd_t            cmd_q;
  logic [3:0]      tx_idx;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      resp_mem [0:63];

  logic            accept, send, store, to_hit;
  logic [3:0]      nargs_clamp;
  logic [6:0]      nresp_clamp;
  logic [2:0]      arg_sel;
  logic [7:0]      tx_byte;

  assign cmd_ready = (state == IDLE);

  assign nargs_clamp = (cmd_nargs > 4'd8)  ? 4'd8  : cmd_nargs;
  assign nresp_clamp = (cmd_nresp > 7'd64) ? 7'd64 : cmd_nresp;

  // tx_idx counts bytes already sent: 0 is the opcode, k>0 is argument byte k-1.
  assign arg_sel = tx_idx[2:0] - 3'd1;
  assign tx_byte = (tx_idx == 4'd0) ? cmd_q.opcode : cmd_q.args[{arg_sel, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    send      = 1'b0;
    store     = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SEND_WAIT;
        end
      end
      SEND_WAIT: begin
        if (!txBusy) begin
          send      = 1'b1;
          state_nxt = SEND_GAP;
        end
      end
      SEND_GAP: begin
        if (tx_idx <= cmd_q.nargs)      state_nxt = SEND_WAIT;
        else if (cmd_q.nresp == 7'd0)   state_nxt = DONE;
        else                            state_nxt = RECV;
      end
      RECV: begin
        // A byte arriving on the timeout clock takes priority over the timeout.
        if (rxReady) begin
          store = 1'b1;
          if (resp_count + 7'd1 == cmd_q.nresp) state_nxt = DONE;
        end else if (to_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= '0;
      tx_idx      <= 4'd0;
      to_cnt      <= '0;
      txStart     <= 1'b0;
      txData      <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      resp_count  <= 7'd0;
    end else begin
      txStart <= send;
      done    <= (state == DONE);

      if (accept) begin
        cmd_q       <= '{opcode: cmd_opcode, nargs: nargs_clamp, args: cmd_args, nresp: nresp_clamp};
        tx_idx      <= 4'd0;
        resp_count  <= 7'd0;
        timeout_err <= 1'b0;
        busy        <= 1'b1;
      end

      if (send) begin
        txData <= tx_byte;
        tx_idx <= tx_idx + 4'd1;
      end

      if (state == SEND_GAP) begin
        to_cnt <= '0;
      end else if (state == RECV) begin
        if (rxReady) to_cnt <= '0;
        else         to_cnt <= to_cnt + 1'b1;
      end

      if (store)  resp_count  <= resp_count + 7'd1;
      if (to_hit) timeout_err <= 1'b1;
      if (state == DONE) busy <= 1'b0;
    end
  end

  // Reply buffer is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (store) resp_mem[resp_count[5:0]] <= rxData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) resp_rd_data <= 8'd0;
    else       resp_rd_data <= resp_mem[resp_rd_addr];
  end

endmodule

// File: tb/tb_serial_cmd_master.sv
// Scoreboard bench for serial_cmd_master: expected tx bytes and done results are queued by stimulus and checked by a monitor.
module tb_serial_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_nargs;
  logic [63:0] cmd_args;
  logic [6:0]  cmd_nresp;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        rxReady;
  logic [7:0]  rxData;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [6:0]  resp_count;
  logic [5:0]  resp_rd_addr;
  logic [7:0]  resp_rd_data;

  serial_cmd_master #(.TIMEOUT_CYCLES(100), .TO_W(24)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_nargs(cmd_nargs), .cmd_args(cmd_args), .cmd_nresp(cmd_nresp),
    .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .rxReady(rxReady), .rxData(rxData),
    .busy(busy), .done(done), .timeout_err(timeout_err), .resp_count(resp_count),
    .resp_rd_addr(resp_rd_addr), .resp_rd_data(resp_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rc;
    int terr;
  } done_t;

  logic [7:0] exp_tx[$];
  done_t      exp_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int tx_seen = 0;
  int done_cnt = 0;
  int last_tx_cyc = 0;
  int done_cyc = 0;
  int terr_cyc = 0;
  logic prev_txstart = 1'b0;
  logic prev_terr = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compares DUT output events against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (txStart) begin
        if (prev_txstart) check("txstart_width", 64'd2, 64'd1);
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", 64'(txData), 64'hFFFF);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          check("tx_byte", 64'(txData), 64'(e));
        end
        tx_seen++;
        last_tx_cyc = cyc;
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_resp_count", 64'(resp_count), 64'(d.rc));
          check("done_timeout_err", 64'(timeout_err), 64'(d.terr));
        end
        done_cnt++;
        done_cyc = cyc;
      end
      if (timeout_err && !prev_terr) terr_cyc = cyc;
    end
    prev_txstart = txStart && !reset;
    prev_terr    = timeout_err && !reset;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [3:0] na, input logic [63:0] a, input logic [6:0] nr);
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      tick(1);
      n++;
    end
    check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
    cmd_opcode = op;
    cmd_nargs  = na;
    cmd_args   = a;
    cmd_nresp  = nr;
    cmd_valid  = 1'b1;
    tick(1);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_seen < target && n < 2000) begin
      tick(1);
      n++;
    end
    check("wait_tx_budget", 64'(tx_seen >= target), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      tick(1);
      n++;
    end
    check("wait_done_budget", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rxReady = 1'b1;
    rxData  = b;
    tick(1);
    rxReady = 1'b0;
  endtask

  task automatic read_buf(input int idx, input logic [7:0] exp, input string name);
    resp_rd_addr = 6'(idx);
    tick(1);
    check(name, 64'(resp_rd_data), 64'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int rx_cyc;
    int n;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = 8'd0; cmd_nargs = 4'd0; cmd_args = 64'd0; cmd_nresp = 7'd0;
    txBusy = 1'b0; rxReady = 1'b0; rxData = 8'd0; resp_rd_addr = 6'd0;
    tick(3);
    check("rst_txStart", 64'(txStart), 64'd0);
    check("rst_txData", 64'(txData), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_resp_count", 64'(resp_count), 64'd0);
    check("rst_resp_rd_data", 64'(resp_rd_data), 64'd0);
    reset = 1'b0;
    tick(1);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    // 1: version query
    exp_tx.push_back(8'h00);
    exp_done.push_back('{rc: 1, terr: 0});
    dbase = done_cnt;
    issue(8'h00, 4'd0, 64'd0, 7'd1);
    check("busy_after_accept", 64'(busy), 64'd1);
    wait_tx(tx_seen + 1);
    tick(3);
    send_rx(8'h08);
    wait_done(dbase + 1);
    tick(2);
    check("t1_single_done", 64'(done_cnt), 64'(dbase + 1));
    check("t1_busy_cleared", 64'(busy), 64'd0);
    read_buf(0, 8'h08, "t1_buf0");

    // 2: seed write, no reply phase
    exp_tx.push_back(8'h06); exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    exp_done.push_back('{rc: 0, terr: 0});
    dbase = done_cnt;
    base  = tx_seen;
    issue(8'h06, 4'd4, 64'h12345678, 7'd0);
    wait_tx(base + 5);
    wait_done(dbase + 1);
    check("t2_done_after_last_tx", 64'(done_cyc - last_tx_cyc), 64'd2);

    // 3: 64-byte counter readout, then a stray byte while idle
    exp_tx.push_back(8'h10);
    exp_done.push_back('{rc: 64, terr: 0});
    dbase = done_cnt;
    base  = tx_seen;
    issue(8'h10, 4'd0, 64'd0, 7'd64);
    wait_tx(base + 1);
    tick(3);
    for (int i = 0; i < 64; i++) begin
      send_rx(8'(i));
      tick(1);
    end
    wait_done(dbase + 1);
    tick(2);
    send_rx(8'hEE);
    tick(2);
    check("t3_count_after_stray", 64'(resp_count), 64'd64);
    check("t3_no_extra_done", 64'(done_cnt), 64'(dbase + 1));
    for (int i = 0; i < 64; i++) read_buf(i, 8'(i), "t3_buf");

    // 4a: timeout after 5 bytes
    exp_tx.push_back(8'h0A);
    exp_done.push_back('{rc: 5, terr: 1});
    dbase = done_cnt;
    base  = tx_seen;
    issue(8'h0A, 4'd0, 64'd0, 7'd32);
    wait_tx(base + 1);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      send_rx(8'hA0 + 8'(i));
      if (i < 4) tick(1);
    end
    rx_cyc = cyc;
    wait_done(dbase + 1);
    check("t4_timeout_err_delay", 64'(terr_cyc - rx_cyc), 64'd100);
    check("t4_done_delay", 64'(done_cyc - rx_cyc), 64'd101);
    read_buf(4, 8'hA4, "t4_buf4");

    // 4b: byte on the 100th idle clock wins over the timeout
    exp_tx.push_back(8'h0A);
    exp_done.push_back('{rc: 6, terr: 1});
    dbase = done_cnt;
    base  = tx_seen;
    issue(8'h0A, 4'd0, 64'd0, 7'd32);
    wait_tx(base + 1);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      send_rx(8'hB0 + 8'(i));
      if (i < 4) tick(1);
    end
    tick(99);
    send_rx(8'h5C);
    rx_cyc = cyc;
    check("t4b_no_timeout_on_byte", 64'(timeout_err), 64'd0);
    check("t4b_count_on_byte", 64'(resp_count), 64'd6);
    wait_done(dbase + 1);
    check("t4b_timeout_err_delay", 64'(terr_cyc - rx_cyc), 64'd100);
    read_buf(5, 8'h5C, "t4b_buf5");

    // 5: backpressure, ignored cmd_valid while busy, nargs clamp
    exp_tx.push_back(8'h20);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
    exp_tx.push_back(8'h55); exp_tx.push_back(8'h66); exp_tx.push_back(8'h77); exp_tx.push_back(8'h88);
    exp_done.push_back('{rc: 0, terr: 0});
    dbase = done_cnt;
    base  = tx_seen;
    txBusy = 1'b1;
    issue(8'h20, 4'd12, 64'h8877665544332211, 7'd0);
    tick(10);
    check("t5_not_ready_while_busy", 64'(cmd_ready), 64'd0);
    check("t5_busy_high", 64'(busy), 64'd1);
    cmd_opcode = 8'h99; cmd_nargs = 4'd1; cmd_args = 64'hFF; cmd_valid = 1'b1;
    tick(2);
    cmd_valid = 1'b0;
    tick(38);
    check("t5_no_tx_while_txbusy", 64'(tx_seen), 64'(base));
    txBusy = 1'b0;
    wait_tx(base + 9);
    wait_done(dbase + 1);
    check("t5_tx_count", 64'(tx_seen), 64'(base + 9));

    // 6: reset in the middle of a send
    exp_tx.push_back(8'h06);
    dbase = done_cnt;
    base  = tx_seen;
    issue(8'h06, 4'd4, 64'hAABBCCDD, 7'd0);
    n = 0;
    while (!(txStart && tx_seen == base + 1) && n < 200) begin
      tick(1);
      n++;
    end
    check("t6_second_tx_seen", 64'(txStart && tx_seen == base + 1), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_txstart_async_drop", 64'(txStart), 64'd0);
    check("t6_busy_async_drop", 64'(busy), 64'd0);
    tick(3);
    reset = 1'b0;
    tick(1);
    check("t6_ready_after_release", 64'(cmd_ready), 64'd1);
    check("t6_no_done", 64'(done_cnt), 64'(dbase));
    exp_tx.push_back(8'h42);
    exp_done.push_back('{rc: 0, terr: 0});
    base = tx_seen;
    issue(8'h42, 4'd0, 64'd0, 7'd0);
    wait_tx(base + 1);
    wait_done(dbase + 1);

    tick(3);
    check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
